// File: rtl/l4_pci_wr_demux4.sv
// ---------------------------------------------------------------------------
// l4_pci_wr_demux4
//
// PCI target write-capture block. It decodes memory-write address phases
// aimed at a 16-byte window and routes each data phase of the burst into one
// of four 32-bit registers. Successive data phases go to successive
// registers, and reg3 wraps to reg0. DEVSEL#/TRDY# are driven with fast
// decode: both assert in the cycle after the address phase.
//
// Parameters:
//   BASE_ADDR  window base. A hit needs ad[31:4] == BASE_ADDR[31:4].
//   RESET_VAL  reset contents of reg0..reg3.
//
// Ports:
//   clk        bus clock. All logic runs on its rising edge.
//   rst_n      synchronous reset, active low. Overrides every other event.
//   frame_n    PCI FRAME#, active low.
//   irdy_n     PCI IRDY#, active low.
//   cbe_n      command in the address phase, byte enables in data phases.
//   ad         PCI AD bus.
//   devsel_n   PCI DEVSEL#, active low, registered.
//   trdy_n     PCI TRDY#, active low, registered.
//   reg0..reg3 captured registers.
//   wr_strobe  one-hot pulse, visible together with the updated register.
//   busy       high whenever the FSM is not idle.
//
// Build option:
//   L4_WR_BYTE_MASK_EN  When defined, each data phase writes only the byte
//                       lanes whose cbe_n bit is 0. When undefined, the full
//                       word is written and data-phase byte enables are
//                       ignored.
// ---------------------------------------------------------------------------
module l4_pci_wr_demux4 #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic [31:0] reg0,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [31:0] reg3,
  output logic [3:0]  wr_strobe,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_SKIP = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        devsel_n_q, devsel_n_d;
  logic        trdy_n_q, trdy_n_d;
  logic [3:0]  wr_strobe_q, wr_strobe_d;
  logic [31:0] regs_q [4];
  logic [31:0] regs_d [4];

  logic        addr_hit;
  logic        cmd_hit;
  logic        xfer;
  logic [31:0] merged_word;

  // Address decode. ad[1:0] plays no part in the match or in the index.
  assign addr_hit = (ad[31:4] == BASE_ADDR[31:4]);
  assign cmd_hit  = (cbe_n == CMD_MEM_WRITE);

  // A data phase completes only when both sides are ready. TRDY# is always
  // low while in DATA, but qualifying on it keeps the handshake explicit.
  assign xfer = (state_q == ST_DATA) && !irdy_n && !trdy_n_q;

  // Build the word written into the targeted register. With byte masking
  // enabled, lanes whose enable is inactive keep their old value.
  always_comb begin
    merged_word = regs_q[idx_q];
`ifdef L4_WR_BYTE_MASK_EN
    for (int k = 0; k < 4; k++) begin
      if (!cbe_n[k]) begin
        merged_word[8*k +: 8] = ad[8*k +: 8];
      end
    end
`else
    merged_word = ad;
`endif
  end

  // Next-state logic. The strobe defaults to 0 so that it pulses for exactly
  // one cycle after each transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    devsel_n_d  = devsel_n_q;
    trdy_n_d    = trdy_n_q;
    wr_strobe_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!frame_n) begin
          idx_d = ad[3:2];
          if (cmd_hit && addr_hit) begin
            state_d    = ST_DATA;
            devsel_n_d = 1'b0;
            trdy_n_d   = 1'b0;
          end else begin
            state_d = ST_SKIP;
          end
        end
      end

      ST_DATA: begin
        if (xfer) begin
          regs_d[idx_q] = merged_word;
          wr_strobe_d   = 4'b0001 << idx_q;
          idx_d         = idx_q + 2'd1;
          if (frame_n) begin
            state_d    = ST_TURN;
            devsel_n_d = 1'b1;
            trdy_n_d   = 1'b1;
          end
        end else if (frame_n && irdy_n) begin
          // The master dropped FRAME# without completing a phase, so the
          // burst is abandoned and nothing is written.
          state_d    = ST_TURN;
          devsel_n_d = 1'b1;
          trdy_n_d   = 1'b1;
        end
      end

      ST_SKIP: begin
        // Another target's transaction. Stay quiet until the bus is idle.
        if (frame_n && irdy_n) begin
          state_d = ST_IDLE;
        end
      end

      ST_TURN: begin
        // Turnaround cycle. FRAME# seen here belongs to the next transaction
        // and is decoded only once the FSM is back in IDLE.
        state_d    = ST_IDLE;
        devsel_n_d = 1'b1;
        trdy_n_d   = 1'b1;
      end

      default: begin
        state_d    = ST_IDLE;
        devsel_n_d = 1'b1;
        trdy_n_d   = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset takes priority over any bus activity,
  // including a burst in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      devsel_n_q  <= 1'b1;
      trdy_n_q    <= 1'b1;
      wr_strobe_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      devsel_n_q  <= devsel_n_d;
      trdy_n_q    <= trdy_n_d;
      wr_strobe_q <= wr_strobe_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign devsel_n  = devsel_n_q;
  assign trdy_n    = trdy_n_q;
  assign wr_strobe = wr_strobe_q;
  assign busy      = (state_q != ST_IDLE);
  assign reg0      = regs_q[0];
  assign reg1      = regs_q[1];
  assign reg2      = regs_q[2];
  assign reg3      = regs_q[3];

endmodule

// File: tb/tb_l4_pci_wr_demux4.sv
// ---------------------------------------------------------------------------
// tb_l4_pci_wr_demux4
//
// Self-checking bench for l4_pci_wr_demux4. The reference model is a
// four-entry array of expected register contents plus the bus-level rules:
// - A claimed burst writes consecutive registers modulo 4.
// - The target's control outputs follow from where the bench is in the
//   transaction.
// Every step drives the inputs, waits for the rising edge, and then samples
// the outputs 1 time unit later.
// ---------------------------------------------------------------------------
module tb_l4_pci_wr_demux4;

  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [31:0] RST_VAL   = 32'h0000_0000;
  localparam logic [6:0]  CTL_IDLE  = 7'b1100000;
  localparam logic [6:0]  CTL_CLAIM = 7'b0010000;
  localparam logic [6:0]  CTL_SKIP  = 7'b1110000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_n = 1'b1;
  logic        irdy_n = 1'b1;
  logic [3:0]  cbe_n = 4'hF;
  logic [31:0] ad = 32'h0;
  logic        devsel_n, trdy_n, busy;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_strobe;

  logic [31:0] dut_regs [4];
  logic [31:0] mdl_regs [4];
  logic [6:0]  ctl;
  int          total = 0;
  int          bad = 0;
  string       tag;

  l4_pci_wr_demux4 #(.BASE_ADDR(BASE), .RESET_VAL(RST_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .cbe_n(cbe_n), .ad(ad), .devsel_n(devsel_n), .trdy_n(trdy_n),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  assign dut_regs[0] = reg0;
  assign dut_regs[1] = reg1;
  assign dut_regs[2] = reg2;
  assign dut_regs[3] = reg3;
  assign ctl = {devsel_n, trdy_n, busy, wr_strobe};

  // Expected register value after one data phase, from the byte-lane rule.
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] data,
                                        input logic [3:0] be_n);
    logic [31:0] r;
    r = data;
`ifdef L4_WR_BYTE_MASK_EN
    for (int k = 0; k < 4; k++) begin
      if (be_n[k]) r[8*k +: 8] = old_v[8*k +: 8];
    end
`else
    r = data | (old_v & 32'h0) | {28'h0, be_n & 4'h0};
`endif
    return r;
  endfunction

  // Drive one bus cycle and move to just after the next rising edge.
  task automatic step(input logic f, input logic ir, input logic [3:0] c, input logic [31:0] a);
    frame_n = f; irdy_n = ir; cbe_n = c; ad = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tag = "reset";
    rst_n = 1'b0;
    step(1'b1, 1'b1, 4'hF, 32'h0);
    step(1'b1, 1'b1, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) mdl_regs[i] = RST_VAL;
    total++;
    if (ctl !== CTL_IDLE) begin
      bad++; $display("[TB] FAIL %s ctl: got %b expected %b", tag, ctl, CTL_IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_regs[i] !== mdl_regs[i]) begin
        bad++; $display("[TB] FAIL %s reg%0d: got %h expected %h", tag, i, dut_regs[i], mdl_regs[i]);
      end
    end
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'hF, 32'h0);
  endtask

  task automatic test_single_write;
    tag = "single_write";
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1008);
    total++;
    if (ctl !== CTL_CLAIM) begin
      bad++; $display("[TB] FAIL %s addr ctl: got %b expected %b", tag, ctl, CTL_CLAIM);
    end
    step(1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF);
    mdl_regs[2] = merge(mdl_regs[2], 32'hDEAD_BEEF, 4'h0);
    total++;
    if (ctl !== 7'b1110100) begin
      bad++; $display("[TB] FAIL %s data ctl: got %b expected %b", tag, ctl, 7'b1110100);
    end
    total++;
    if (reg2 !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL %s reg2: got %h expected %h", tag, reg2, 32'hDEAD_BEEF);
    end
    step(1'b1, 1'b1, 4'hF, 32'h0);
    total++;
    if (ctl !== CTL_IDLE) begin
      bad++; $display("[TB] FAIL %s turn ctl: got %b expected %b", tag, ctl, CTL_IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_regs[i] !== mdl_regs[i]) begin
        bad++; $display("[TB] FAIL %s reg%0d: got %h expected %h", tag, i, dut_regs[i], mdl_regs[i]);
      end
    end
  endtask

  task automatic test_burst_wrap;
    logic        fr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ir [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] d;
    logic [31:0] last_d;
    logic [6:0]  exp;
    int          widx;
    tag = "burst_wrap";
    last_d = 32'h0;
    step(1'b0, 1'b1, 4'b0111, 32'h0000_100C);
    widx = 3;
    for (int p = 0; p < 7; p++) begin
      d = $urandom;
      step(fr[p], ir[p], 4'h0, d);
      exp = CTL_CLAIM;
      if (!ir[p]) begin
        mdl_regs[widx] = merge(mdl_regs[widx], d, 4'h0);
        exp[3:0] = 4'(1 << widx);
        widx = (widx + 1) % 4;
        last_d = d;
      end
      if (fr[p]) exp[6:5] = 2'b11;
      total++;
      if (ctl !== exp) begin
        bad++; $display("[TB] FAIL %s phase%0d ctl: got %b expected %b", tag, p, ctl, exp);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dut_regs[i] !== mdl_regs[i]) begin
          bad++; $display("[TB] FAIL %s phase%0d reg%0d: got %h expected %h", tag, p, i, dut_regs[i], mdl_regs[i]);
        end
      end
    end
    total++;
    if (reg3 !== last_d) begin
      bad++; $display("[TB] FAIL %s reg3 final: got %h expected %h", tag, reg3, last_d);
    end
    step(1'b1, 1'b1, 4'hF, 32'h0);
    total++;
    if (ctl !== CTL_IDLE) begin
      bad++; $display("[TB] FAIL %s idle ctl: got %b expected %b", tag, ctl, CTL_IDLE);
    end
  endtask

  task automatic test_miss;
    logic [31:0] addrs [2] = '{32'h0000_2000, 32'h0000_1000};
    logic [3:0]  cmds  [2] = '{4'b0111, 4'b0110};
    tag = "miss";
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b1, cmds[c], addrs[c]);
      total++;
      if (ctl !== CTL_SKIP) begin
        bad++; $display("[TB] FAIL %s%0d addr ctl: got %b expected %b", tag, c, ctl, CTL_SKIP);
      end
      step(1'b0, 1'b0, 4'h0, $urandom);
      step(1'b1, 1'b0, 4'h0, $urandom);
      total++;
      if (ctl !== CTL_SKIP) begin
        bad++; $display("[TB] FAIL %s%0d data ctl: got %b expected %b", tag, c, ctl, CTL_SKIP);
      end
      step(1'b1, 1'b1, 4'hF, 32'h0);
      total++;
      if (ctl !== CTL_IDLE) begin
        bad++; $display("[TB] FAIL %s%0d idle ctl: got %b expected %b", tag, c, ctl, CTL_IDLE);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dut_regs[i] !== mdl_regs[i]) begin
          bad++; $display("[TB] FAIL %s%0d reg%0d: got %h expected %h", tag, c, i, dut_regs[i], mdl_regs[i]);
        end
      end
    end
  endtask

  task automatic test_master_abort;
    tag = "master_abort";
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1004);
    step(1'b1, 1'b1, 4'h0, $urandom);
    total++;
    if (ctl !== 7'b1110000) begin
      bad++; $display("[TB] FAIL %s ctl: got %b expected %b", tag, ctl, 7'b1110000);
    end
    step(1'b1, 1'b1, 4'hF, 32'h0);
    total++;
    if (ctl !== CTL_IDLE) begin
      bad++; $display("[TB] FAIL %s idle ctl: got %b expected %b", tag, ctl, CTL_IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_regs[i] !== mdl_regs[i]) begin
        bad++; $display("[TB] FAIL %s reg%0d: got %h expected %h", tag, i, dut_regs[i], mdl_regs[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    tag = "back_to_back";
    d = $urandom;
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1004);
    step(1'b1, 1'b0, 4'h0, d);
    mdl_regs[1] = merge(mdl_regs[1], d, 4'h0);
    // FRAME# asserted during turnaround must not be claimed.
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1000);
    total++;
    if (ctl !== CTL_IDLE) begin
      bad++; $display("[TB] FAIL %s turn ctl: got %b expected %b", tag, ctl, CTL_IDLE);
    end
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1000);
    total++;
    if (ctl !== CTL_CLAIM) begin
      bad++; $display("[TB] FAIL %s reclaim ctl: got %b expected %b", tag, ctl, CTL_CLAIM);
    end
    d = $urandom;
    step(1'b1, 1'b0, 4'h0, d);
    mdl_regs[0] = merge(mdl_regs[0], d, 4'h0);
    total++;
    if (ctl !== 7'b1110001) begin
      bad++; $display("[TB] FAIL %s data ctl: got %b expected %b", tag, ctl, 7'b1110001);
    end
    step(1'b1, 1'b1, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_regs[i] !== mdl_regs[i]) begin
        bad++; $display("[TB] FAIL %s reg%0d: got %h expected %h", tag, i, dut_regs[i], mdl_regs[i]);
      end
    end
  endtask

  task automatic test_byte_mask;
    logic [31:0] exp;
    tag = "byte_mask";
`ifdef L4_WR_BYTE_MASK_EN
    exp = 32'h11BB_11DD;
`else
    exp = 32'hAABB_CCDD;
`endif
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1004);
    step(1'b1, 1'b0, 4'h0, 32'h1111_1111);
    mdl_regs[1] = merge(mdl_regs[1], 32'h1111_1111, 4'h0);
    step(1'b1, 1'b1, 4'hF, 32'h0);
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1004);
    step(1'b1, 1'b0, 4'b1010, 32'hAABB_CCDD);
    mdl_regs[1] = merge(mdl_regs[1], 32'hAABB_CCDD, 4'b1010);
    total++;
    if (reg1 !== exp) begin
      bad++; $display("[TB] FAIL %s reg1: got %h expected %h", tag, reg1, exp);
    end
    total++;
    if (wr_strobe !== 4'b0010) begin
      bad++; $display("[TB] FAIL %s strobe: got %b expected %b", tag, wr_strobe, 4'b0010);
    end
    step(1'b1, 1'b1, 4'hF, 32'h0);
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] d;
    tag = "reset_mid_burst";
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1000);
    step(1'b0, 1'b0, 4'h0, $urandom);
    step(1'b0, 1'b0, 4'h0, $urandom);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 4'h0, $urandom);
    for (int i = 0; i < 4; i++) mdl_regs[i] = RST_VAL;
    total++;
    if (ctl !== CTL_IDLE) begin
      bad++; $display("[TB] FAIL %s ctl: got %b expected %b", tag, ctl, CTL_IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_regs[i] !== mdl_regs[i]) begin
        bad++; $display("[TB] FAIL %s reg%0d: got %h expected %h", tag, i, dut_regs[i], mdl_regs[i]);
      end
    end
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'h0, $urandom);
    total++;
    if (ctl !== CTL_IDLE) begin
      bad++; $display("[TB] FAIL %s tail ctl: got %b expected %b", tag, ctl, CTL_IDLE);
    end
    step(1'b1, 1'b1, 4'hF, 32'h0);
    d = $urandom;
    step(1'b0, 1'b1, 4'b0111, 32'h0000_1008);
    step(1'b1, 1'b0, 4'h0, d);
    mdl_regs[2] = merge(mdl_regs[2], d, 4'h0);
    total++;
    if (ctl !== 7'b1110100) begin
      bad++; $display("[TB] FAIL %s rewrite ctl: got %b expected %b", tag, ctl, 7'b1110100);
    end
    step(1'b1, 1'b1, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_regs[i] !== mdl_regs[i]) begin
        bad++; $display("[TB] FAIL %s rewrite reg%0d: got %h expected %h", tag, i, dut_regs[i], mdl_regs[i]);
      end
    end
  endtask

  task automatic test_random_bursts;
    logic        hit, last;
    logic [31:0] addr, d;
    logic [3:0]  cmd, be;
    logic [6:0]  exp;
    int          nph, widx, waits;
    tag = "random";
    for (int b = 0; b < 40; b++) begin
      hit  = ($urandom_range(0, 9) < 6);
      addr = {BASE[31:4], 4'($urandom_range(0, 15))};
      cmd  = 4'b0111;
      if (!hit) begin
        if ($urandom_range(0, 1) == 1) begin
          addr = $urandom;
          if (addr[31:4] == BASE[31:4]) addr[31] = ~addr[31];
        end else begin
          cmd = 4'($urandom_range(0, 15));
          if (cmd == 4'b0111) cmd = 4'b0110;
        end
      end
      nph  = $urandom_range(1, 6);
      widx = int'(addr[3:2]);
      step(1'b0, 1'b1, cmd, addr);
      total++;
      if (ctl !== (hit ? CTL_CLAIM : CTL_SKIP)) begin
        bad++; $display("[TB] FAIL %s b%0d addr ctl: got %b expected %b", tag, b, ctl, hit ? CTL_CLAIM : CTL_SKIP);
      end
      for (int p = 0; p < nph; p++) begin
        waits = $urandom_range(0, 2);
        for (int w = 0; w < waits; w++) begin
          step(1'b0, 1'b1, 4'h0, $urandom);
          total++;
          if (ctl !== (hit ? CTL_CLAIM : CTL_SKIP)) begin
            bad++; $display("[TB] FAIL %s b%0d wait ctl: got %b expected %b", tag, b, ctl, hit ? CTL_CLAIM : CTL_SKIP);
          end
        end
        last = (p == nph - 1);
        be   = 4'($urandom_range(0, 15));
        d    = $urandom;
        step(last, 1'b0, be, d);
        exp = CTL_SKIP;
        if (hit) begin
          mdl_regs[widx] = merge(mdl_regs[widx], d, be);
          exp = {last ? 2'b11 : 2'b00, 1'b1, 4'(1 << widx)};
          widx = (widx + 1) % 4;
        end
        total++;
        if (ctl !== exp) begin
          bad++; $display("[TB] FAIL %s b%0d p%0d ctl: got %b expected %b", tag, b, p, ctl, exp);
        end
        for (int i = 0; i < 4; i++) begin
          total++;
          if (dut_regs[i] !== mdl_regs[i]) begin
            bad++; $display("[TB] FAIL %s b%0d p%0d reg%0d: got %h expected %h", tag, b, p, i, dut_regs[i], mdl_regs[i]);
          end
        end
      end
      step(1'b1, 1'b1, 4'hF, 32'h0);
      total++;
      if (ctl !== CTL_IDLE) begin
        bad++; $display("[TB] FAIL %s b%0d idle ctl: got %b expected %b", tag, b, ctl, CTL_IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_miss();
    test_master_abort();
    test_back_to_back();
    test_byte_mask();
    test_reset_mid_burst();
    test_random_bursts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
